// File: rtl/free_list_if.sv
// Allocation/free handshake bundle between the write controllers, the egress
// free path and the free-list manager.
interface free_list_if #(
  parameter int N_PORTS = 4,
  parameter int ADDR_W  = 8
);
  logic [N_PORTS-1:0] alloc_req_i;
  logic [N_PORTS-1:0] alloc_gnt_o;
  logic [ADDR_W-1:0]  alloc_idx_o;
  logic               free_valid_i;
  logic [ADDR_W-1:0]  free_idx_i;
  logic               free_ready_o;
  logic               init_done_o;
  logic [ADDR_W:0]    free_count_o;
  logic               empty_o;
  logic               overflow_err_o;

  modport slave (
    input  alloc_req_i,
    input  free_valid_i,
    input  free_idx_i,
    output alloc_gnt_o,
    output alloc_idx_o,
    output free_ready_o,
    output init_done_o,
    output free_count_o,
    output empty_o,
    output overflow_err_o
  );

  modport master (
    output alloc_req_i,
    output free_valid_i,
    output free_idx_i,
    input  alloc_gnt_o,
    input  alloc_idx_o,
    input  free_ready_o,
    input  init_done_o,
    input  free_count_o,
    input  empty_o,
    input  overflow_err_o
  );
endinterface

// File: rtl/free_list_mgr.sv
// Free-list manager: circular pool of buffer block indices, round-robin
// allocation to N_PORTS requesters, one grant per cycle, returned indices pushed back.
module free_list_mgr #(
  parameter int N_PORTS    = 4,
  parameter int NUM_BLOCKS = 256,
  parameter int ADDR_W     = $clog2(NUM_BLOCKS)
) (
  input  logic         clk,
  input  logic         rst_n,
  free_list_if.slave   bus
);

  localparam int              PTR_W    = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(NUM_BLOCKS);
  localparam logic [PTR_W:0]  NP_EXT   = (PTR_W+1)'(N_PORTS);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] head_q, head_d;
  logic [ADDR_W-1:0] tail_q, tail_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [PTR_W-1:0]  rr_q, rr_d;
  logic              empty_q;
  logic              ovf_q, ovf_d;

  logic [ADDR_W-1:0] mem [NUM_BLOCKS];
  logic [ADDR_W-1:0] head_data_q;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] wr_data;

  logic [N_PORTS-1:0] gnt;
  logic [PTR_W-1:0]   win;
  logic [PTR_W:0]     cand;
  logic               any_win;
  logic               grant_en;
  logic               pop;
  logic               push_req;
  logic               push_ok;
  logic               full;

  // First requester at or after the RR pointer, searching modulo N_PORTS.
  always_comb begin
    win     = rr_q;
    any_win = 1'b0;
    cand    = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      cand = {1'b0, rr_q} + (PTR_W+1)'(i);
      if (cand >= NP_EXT) begin
        cand = cand - NP_EXT;
      end
      if (!any_win && bus.alloc_req_i[cand[PTR_W-1:0]]) begin
        any_win = 1'b1;
        win     = cand[PTR_W-1:0];
      end
    end
  end

  assign grant_en = (state_q == ST_RUN) && (count_q != '0) && any_win;

  for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_gnt
    assign gnt[gi] = grant_en && (win == PTR_W'(gi));
  end

  assign pop      = grant_en;
  assign full     = (count_q == FULL_CNT);
  assign push_req = bus.free_valid_i && (state_q == ST_RUN);
  assign push_ok  = push_req && !full;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    rr_d    = rr_q;
    ovf_d   = ovf_q;
    wr_en   = 1'b0;
    wr_addr = tail_q;
    wr_data = bus.free_idx_i;

    case (state_q)
      ST_INIT: begin
        // Entry i gets value i; tail doubles as the init counter.
        wr_en   = 1'b1;
        wr_data = tail_q;
        tail_d  = tail_q + 1'b1;
        count_d = count_q + 1'b1;
        if (count_q == FULL_CNT - 1'b1) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (pop) begin
          head_d = head_q + 1'b1;
          rr_d   = (win == PTR_W'(N_PORTS - 1)) ? '0 : win + 1'b1;
        end
        if (push_ok) begin
          wr_en  = 1'b1;
          tail_d = tail_q + 1'b1;
        end
        if (push_req && full) begin
          ovf_d = 1'b1;
        end
        case ({push_ok, pop})
          2'b10:   count_d = count_q + 1'b1;
          2'b01:   count_d = count_q - 1'b1;
          default: count_d = count_q;
        endcase
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      rr_q    <= '0;
      empty_q <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      rr_q    <= rr_d;
      empty_q <= (count_d == '0);
      ovf_q   <= ovf_d;
    end
  end

  // Registered read of the next head entry; a write landing on that address
  // (pool was empty, or count==1 with push+pop) is forwarded.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    head_data_q <= (wr_en && (wr_addr == head_d)) ? wr_data : mem[head_d];
  end

  assign bus.alloc_gnt_o    = gnt;
  assign bus.alloc_idx_o    = head_data_q;
  assign bus.free_ready_o   = (state_q == ST_RUN);
  assign bus.init_done_o    = (state_q == ST_RUN);
  assign bus.free_count_o   = count_q;
  assign bus.empty_o        = empty_q;
  assign bus.overflow_err_o = ovf_q;

endmodule

// File: tb/tb_free_list_mgr.sv
// Bench for free_list_mgr: directed table, corner sequences and randomized
// traffic, all compared against a queue-based pool model.
module tb_free_list_mgr;

  localparam int NP = 4;
  localparam int NB = 256;
  localparam int AW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  free_list_if #(.N_PORTS(NP), .ADDR_W(AW)) bus ();

  free_list_mgr #(.N_PORTS(NP), .NUM_BLOCKS(NB), .ADDR_W(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: pool contents in FIFO order, RR pointer, sticky overflow.
  int pool[$];
  int rr;
  bit ovf;

  typedef struct {
    logic [3:0] req;
    bit         fv;
    int         fi;
    logic [3:0] gnt;
    int         idx;
    int         cnt;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    pool.delete();
    rr  = 0;
    ovf = 0;
  endtask

  // One RUN-state cycle: drive at negedge, compare, then advance the model.
  task automatic cycle(input logic [3:0] req, input bit fv, input int fi,
                       output logic [3:0] g, output int gi);
    logic [3:0] exp_g;
    int         win;
    bit         was_full;
    @(negedge clk);
    bus.alloc_req_i  = req;
    bus.free_valid_i = fv;
    bus.free_idx_i   = AW'(fi);
    #1;
    exp_g = '0;
    win   = -1;
    if (pool.size() > 0) begin
      for (int k = 0; k < NP; k++) begin
        int p;
        p = (rr + k) % NP;
        if (win < 0 && req[p]) win = p;
      end
    end
    if (win >= 0) exp_g[win] = 1'b1;
    chk("gnt", 32'(bus.alloc_gnt_o), 32'(exp_g));
    if (win >= 0) chk("idx", 32'(bus.alloc_idx_o), 32'(pool[0]));
    chk("count", 32'(bus.free_count_o), 32'(pool.size()));
    chk("empty", 32'(bus.empty_o), 32'(pool.size() == 0));
    chk("overflow", 32'(bus.overflow_err_o), 32'(ovf));
    chk("ready", 32'(bus.free_ready_o), 32'd1);
    chk("init_done", 32'(bus.init_done_o), 32'd1);
    g  = bus.alloc_gnt_o;
    gi = int'(bus.alloc_idx_o);
    $display("cyc req=%b fv=%0d fi=%0d gnt=%b idx=%0d cnt=%0d ovf=%0d",
             req, fv, fi, g, gi, bus.free_count_o, bus.overflow_err_o);
    was_full = (pool.size() == NB);
    if (win >= 0) begin
      void'(pool.pop_front());
      rr = (win + 1) % NP;
    end
    if (fv) begin
      if (was_full) ovf = 1;
      else pool.push_back(fi);
    end
  endtask

  // Let the edge of the last cycle land so registered outputs can be read.
  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  // Release reset and walk the INIT fill; requests and frees must be ignored.
  task automatic do_init();
    @(negedge clk);
    bus.alloc_req_i  = 4'hF;
    bus.free_valid_i = 1'b1;
    bus.free_idx_i   = AW'(123);
    rst_n = 1'b1;
    for (int k = 0; k < NB; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      chk("init_gnt", 32'(bus.alloc_gnt_o), 32'd0);
      chk("init_ready", 32'(bus.free_ready_o), 32'd0);
      chk("init_done_low", 32'(bus.init_done_o), 32'd0);
      chk("init_count", 32'(bus.free_count_o), 32'(k));
    end
    model_reset();
    for (int k = 0; k < NB; k++) pool.push_back(k);
    $display("init sequence walked, %0d entries", NB);
  endtask

  initial begin
    logic [3:0] g;
    int         gi;
    int         n;

    tbl[0]  = '{4'b1111, 0, 0,   4'b0001, 0, 256};
    tbl[1]  = '{4'b1111, 0, 0,   4'b0010, 1, 255};
    tbl[2]  = '{4'b1111, 0, 0,   4'b0100, 2, 254};
    tbl[3]  = '{4'b1111, 0, 0,   4'b1000, 3, 253};
    tbl[4]  = '{4'b1111, 0, 0,   4'b0001, 4, 252};
    tbl[5]  = '{4'b0000, 1, 200, 4'b0000, 0, 251};
    tbl[6]  = '{4'b0101, 0, 0,   4'b0100, 5, 252};
    tbl[7]  = '{4'b0101, 0, 0,   4'b0001, 6, 251};
    tbl[8]  = '{4'b1001, 0, 0,   4'b1000, 7, 250};
    tbl[9]  = '{4'b0110, 1, 33,  4'b0010, 8, 249};
    tbl[10] = '{4'b0000, 0, 0,   4'b0000, 0, 249};

    bus.alloc_req_i  = '0;
    bus.free_valid_i = 1'b0;
    bus.free_idx_i   = '0;
    model_reset();

    repeat (2) @(negedge clk);
    #1;
    chk("rst_gnt", 32'(bus.alloc_gnt_o), 32'd0);
    chk("rst_init_done", 32'(bus.init_done_o), 32'd0);
    chk("rst_ready", 32'(bus.free_ready_o), 32'd0);
    chk("rst_count", 32'(bus.free_count_o), 32'd0);
    chk("rst_empty", 32'(bus.empty_o), 32'd1);
    chk("rst_overflow", 32'(bus.overflow_err_o), 32'd0);

    do_init();

    // Directed table: round-robin order, index sequence, push/pop counts.
    for (int i = 0; i < 11; i++) begin
      cycle(tbl[i].req, tbl[i].fv, tbl[i].fi, g, gi);
      chk("tbl_gnt", 32'(g), 32'(tbl[i].gnt));
      if (tbl[i].gnt != 0) chk("tbl_idx", 32'(gi), 32'(tbl[i].idx));
      chk("tbl_count", 32'(bus.free_count_o), 32'(tbl[i].cnt));
    end

    // Exhaustion then single-block refill.
    n = 0;
    while (pool.size() > 0 && n < 300) begin
      cycle(4'hF, 0, 0, g, gi);
      n++;
    end
    settle();
    chk("drain_empty", 32'(bus.empty_o), 32'd1);
    chk("drain_count", 32'(bus.free_count_o), 32'd0);
    for (int i = 0; i < 3; i++) begin
      cycle(4'hF, 0, 0, g, gi);
      chk("empty_hold_gnt", 32'(g), 32'd0);
    end
    cycle(4'hF, 1, 17, g, gi);
    chk("no_bypass_gnt", 32'(g), 32'd0);
    cycle(4'hF, 0, 0, g, gi);
    chk("refill_gnt_any", 32'(g != 0), 32'd1);
    chk("refill_idx", 32'(gi), 32'd17);
    settle();
    chk("refill_empty", 32'(bus.empty_o), 32'd1);

    // Concurrent push and pop at count==1.
    cycle(4'h0, 1, 50, g, gi);
    cycle(4'hF, 1, 99, g, gi);
    chk("conc_gnt_any", 32'(g != 0), 32'd1);
    chk("conc_idx_old", 32'(gi), 32'd50);
    settle();
    chk("conc_count", 32'(bus.free_count_o), 32'd1);
    cycle(4'hF, 0, 0, g, gi);
    chk("conc_idx_new", 32'(gi), 32'd99);

    // Fill to full, then overflow.
    n = 0;
    while (pool.size() < NB && n < 300) begin
      cycle(4'h0, 1, int'($urandom_range(0, NB - 1)), g, gi);
      n++;
    end
    chk("fill_bound", 32'(pool.size()), 32'(NB));
    cycle(4'h0, 1, 5, g, gi);
    settle();
    chk("ovf_set", 32'(bus.overflow_err_o), 32'd1);
    chk("ovf_count", 32'(bus.free_count_o), 32'(NB));
    cycle(4'b0010, 0, 0, g, gi);
    chk("ovf_gnt", 32'(g), 32'b0010);
    cycle(4'h0, 0, 0, g, gi);
    chk("ovf_sticky", 32'(bus.overflow_err_o), 32'd1);

    // Randomized traffic: drain-biased, fill-biased, balanced.
    for (int ph = 0; ph < 3; ph++) begin
      int preq;
      int pfree;
      preq  = (ph == 0) ? 85 : (ph == 1) ? 15 : 50;
      pfree = (ph == 0) ? 20 : (ph == 1) ? 90 : 50;
      for (int i = 0; i < 500; i++) begin
        logic [3:0] rq;
        bit         fv;
        rq = ($urandom_range(0, 99) < preq) ? 4'($urandom_range(1, 15)) : 4'h0;
        fv = ($urandom_range(0, 99) < pfree);
        cycle(rq, fv, int'($urandom_range(0, NB - 1)), g, gi);
      end
    end

    // Reset mid-run with count==100 and requests active.
    n = 0;
    while (pool.size() != 100 && n < 600) begin
      if (pool.size() > 100) cycle(4'hF, 0, 0, g, gi);
      else cycle(4'h0, 1, int'($urandom_range(0, NB - 1)), g, gi);
      n++;
    end
    settle();
    chk("pre_rst_count", 32'(bus.free_count_o), 32'd100);
    @(negedge clk);
    bus.alloc_req_i = 4'hF;
    rst_n = 1'b0;
    #1;
    chk("midrst_gnt", 32'(bus.alloc_gnt_o), 32'd0);
    chk("midrst_init_done", 32'(bus.init_done_o), 32'd0);
    chk("midrst_count", 32'(bus.free_count_o), 32'd0);
    chk("midrst_empty", 32'(bus.empty_o), 32'd1);
    chk("midrst_overflow", 32'(bus.overflow_err_o), 32'd0);
    model_reset();
    do_init();
    cycle(4'b0100, 0, 0, g, gi);
    chk("post_rst_gnt", 32'(g), 32'b0100);
    chk("post_rst_idx", 32'(gi), 32'd0);
    cycle(4'b0101, 0, 0, g, gi);
    chk("post_rst_gnt2", 32'(g), 32'b0001);
    chk("post_rst_idx2", 32'(gi), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

endmodule

// File: doc/free_list_mgr.md
Name: free_list_mgr

Overview:
Owns the pool of free cell-block indices for the shared packet buffer. It arbitrates allocation requests from N_PORTS memory write controllers with a round-robin policy and hands out one index per cycle. It accepts returned indices from the memory read/egress side. It sits between the per-port write controllers (fl_alloc_req/gnt/idx handshake) and the dual-port cell memory's block address space.

Parameters:
N_PORTS, 4, number of allocation requesters (write controllers)
NUM_BLOCKS, 256, number of cell blocks in buffer memory; must be a power of 2
ADDR_W, $clog2(NUM_BLOCKS), block index width (matches mem_pkg ADDR_W)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
alloc_req_i  in  N_PORTS  per-port allocation request; held until granted
alloc_gnt_o  out  N_PORTS  one-hot grant; asserted in the same cycle as the winning request
alloc_idx_o  out  ADDR_W  allocated index; valid only while any alloc_gnt_o bit is high
free_valid_i  in  1  return one index to the pool
free_idx_i  in  ADDR_W  index being returned
free_ready_o  out  1  free accepted when valid&ready
init_done_o  out  1  pool initialised; allocation enabled
free_count_o  out  ADDR_W+1  number of indices currently in pool
empty_o  out  1  free_count_o == 0
overflow_err_o  out  1  sticky: free pushed while pool full

Behaviour:
- Single clock, asynchronous active-low reset on rst_n.
- Reset values: alloc_gnt_o=0, init_done_o=0, free_ready_o=0, free_count_o=0, empty_o=1, overflow_err_o=0.
- After reset: head=tail=0, RR pointer=0, state=INIT.
- Storage: circular buffer of NUM_BLOCKS x ADDR_W entries.
  - head and tail are ADDR_W bits and wrap naturally.
  - count is ADDR_W+1 bits.
- State INIT:
  - An init counter writes value i to entry i, one per cycle, incrementing tail and count.
  - After NUM_BLOCKS cycles: count=NUM_BLOCKS, tail=0; go to RUN and set init_done_o=1.
  - No grants and free_ready_o=0 throughout INIT.
- State RUN: free_ready_o=1 every cycle.
- Grant (combinational from registered state):
  - If count>0 and any alloc_req_i bit is set, grant exactly one port.
  - Winner is the first requesting port at or after the RR pointer, searching modulo N_PORTS.
  - alloc_idx_o = entry[head]; pop on grant (head+1, count-1).
  - The requester captures alloc_idx_o on the grant cycle and must drop req the next cycle unless it wants another block.
- RR pointer update: after a grant to port k, pointer <= (k+1) mod N_PORTS. With no grant it is unchanged.
- Throughput: at most 1 grant per cycle.
- Free:
  - On free_valid_i && free_ready_o, write free_idx_i to entry[tail]; tail+1, count+1.
  - If count==NUM_BLOCKS at the push, drop the push, set overflow_err_o (sticky until reset), leave count unchanged.
- Simultaneous push and pop in one cycle: both occur and count is unchanged.
  - No bypass: when empty, a free in cycle t is grantable in cycle t+1 at the earliest.
- Empty: with count==0, alloc_gnt_o=0 regardless of requests; requesters keep waiting.
- Outputs: free_count_o and empty_o are registered and reflect post-update state one cycle after the event.
- No duplicate-free detection beyond the overflow check; freed index values are not checked.
- Reset asserted mid-operation: all state clears immediately, outstanding requests are ignored, and the pool is rebuilt via INIT.

Test Plan:
- Init: release reset, no requests -> init_done_o rises after 256 cycles, free_count_o=256; a single req on port 2 -> same-cycle gnt=4'b0100, idx=0.
- Round-robin: ports 0-3 requesting continuously from init_done -> grants to ports 0,1,2,3,0 with idx 0,1,2,3,4; free_count_o decrements by 1 per cycle.
- Exhaustion and refill: allocate all 256 -> empty_o=1, requests held with gnt=0; free idx 17 -> next cycle gnt issued with idx=17, empty_o returns to 1.
- Concurrent push and pop: at count=1, free idx 99 and alloc in the same cycle -> grant returns the old head, count stays 1, and the next grant returns 99.
- Overflow: at count=256, push idx 5 -> overflow_err_o=1 and stays set, count=256, subsequent grants unaffected.
- Reset mid-run: assert rst_n=0 with count=100 and requests active -> gnt=0, init_done_o=0 at once; after release, INIT rebuilds and the first grant is idx 0.
